// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / data) in front of a single memory port.
// Data wins by default; fetch is forced through after STARVE_MAX back-to-back data grants.
module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_done_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic [DW-1:0] d_rdata_o,
    output logic          d_done_o,
    output logic          m_req_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_addr_o,
    output logic [DW-1:0] m_wdata_o,
    input  logic          m_ack_i,
    input  logic [DW-1:0] m_rdata_i
);

    localparam int SCW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [SCW-1:0] starve_q, starve_d;
    logic [AW-1:0]  m_addr_q, m_addr_d;
    logic [DW-1:0]  m_wdata_q, m_wdata_d;
    logic           m_we_q, m_we_d;
    logic [DW-1:0]  if_rdata_q, if_rdata_d;
    logic [DW-1:0]  d_rdata_q, d_rdata_d;
    logic           if_done_q, if_done_d;
    logic           d_done_q, d_done_d;
    logic           any_done;
    logic           if_want;
    logic           d_want;

    // No grant in a done cycle: a requester still holding its level request
    // cannot be re-served on a stale request, and the other side waits one cycle
    // so the starvation count sees the refreshed request set.
    assign any_done = if_done_q | d_done_q;
    assign if_want  = if_req_i & ~any_done;
    assign d_want   = d_req_i & ~any_done;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_we_d     = m_we_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_want && (!if_want || (starve_q < STARVE_LIM))) begin
                    state_d   = SERVE_D;
                    m_addr_d  = d_addr_i;
                    m_we_d    = d_we_i;
                    m_wdata_d = d_wdata_i;
                    if (if_want)
                        starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SCW'(1);
                    else
                        starve_d = '0;
                end else if (if_want) begin
                    state_d   = SERVE_I;
                    m_addr_d  = if_addr_i;
                    m_we_d    = 1'b0;
                    m_wdata_d = '0;
                    starve_d  = '0;
                end
            end
            SERVE_I: begin
                if (m_ack_i) begin
                    state_d    = IDLE;
                    if_done_d  = 1'b1;
                    if_rdata_d = m_rdata_i;
                end
            end
            SERVE_D: begin
                if (m_ack_i) begin
                    state_d  = IDLE;
                    d_done_d = 1'b1;
                    if (!m_we_q)
                        d_rdata_d = m_rdata_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_we_q     <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_we_q     <= m_we_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
        end
    end

    assign m_req_o    = (state_q != IDLE);
    assign m_we_o     = m_we_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
    assign if_rdata_o = if_rdata_q;
    assign d_rdata_o  = d_rdata_q;
    assign if_done_o  = if_done_q;
    assign d_done_o   = d_done_q;

endmodule
